// File: rtl/cordic_iter_engine.sv
// cordic_iter_engine
// Iterative shift-add CORDIC core. Each accepted operation performs one
// micro-rotation per clock for ITERS clocks, then presents the result until
// the consumer takes it.
//   in_mode = 0 : ROTATION  - drives z toward 0, x/y become K^-1 * (cos, sin)
//   in_mode = 1 : VECTORING - drives y toward 0, x becomes K^-1 * magnitude,
//                             z accumulates atan(y/x)
// No gain compensation is applied; callers pre-scale by K = 0.607253.
//
// Ports
//   clk                  rising-edge clock
//   reset                asynchronous, active-high; aborts any operation
//   in_valid / in_ready  operand handshake (in_ready high only while idle)
//   in_mode              mode select, captured at accept
//   in_x, in_y, in_z     signed operands, FRAC = WIDTH-3 fraction bits
//   out_valid/out_ready  result handshake; result held until consumed
//   out_x, out_y, out_z  signed saturated results, same format as inputs
module cordic_iter_engine #(
    parameter int WIDTH = 21,
    parameter int ITERS = 16,
    parameter int GUARD = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic signed [WIDTH-1:0] in_z,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_x,
    output logic signed [WIDTH-1:0] out_y,
    output logic signed [WIDTH-1:0] out_z
);

    localparam int FRAC = WIDTH - 3;
    localparam int IW   = WIDTH + 2 * GUARD;
    localparam int CW   = $clog2(ITERS);

    // The atan table is Q3.29; it must land on FRAC+GUARD fraction bits.
    localparam int ATAN_SHIFT = 29 - FRAC - GUARD;
    localparam int ATAN_RSH   = (ATAN_SHIFT > 0) ? ATAN_SHIFT : 0;
    localparam int ATAN_LSH   = (ATAN_SHIFT < 0) ? -ATAN_SHIFT : 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // round(atan(2^-i) * 2^29)
    function automatic logic signed [31:0] atan_q29(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_q29 = 32'sd421657428;
            5'd1:    atan_q29 = 32'sd248918915;
            5'd2:    atan_q29 = 32'sd131521918;
            5'd3:    atan_q29 = 32'sd66762579;
            5'd4:    atan_q29 = 32'sd33510843;
            5'd5:    atan_q29 = 32'sd16771758;
            5'd6:    atan_q29 = 32'sd8387925;
            5'd7:    atan_q29 = 32'sd4194219;
            5'd8:    atan_q29 = 32'sd2097141;
            5'd9:    atan_q29 = 32'sd1048575;
            5'd10:   atan_q29 = 32'sd524288;
            5'd11:   atan_q29 = 32'sd262144;
            5'd12:   atan_q29 = 32'sd131072;
            5'd13:   atan_q29 = 32'sd65536;
            5'd14:   atan_q29 = 32'sd32768;
            5'd15:   atan_q29 = 32'sd16384;
            5'd16:   atan_q29 = 32'sd8192;
            5'd17:   atan_q29 = 32'sd4096;
            5'd18:   atan_q29 = 32'sd2048;
            5'd19:   atan_q29 = 32'sd1024;
            5'd20:   atan_q29 = 32'sd512;
            5'd21:   atan_q29 = 32'sd256;
            5'd22:   atan_q29 = 32'sd128;
            5'd23:   atan_q29 = 32'sd64;
            5'd24:   atan_q29 = 32'sd32;
            5'd25:   atan_q29 = 32'sd16;
            5'd26:   atan_q29 = 32'sd8;
            5'd27:   atan_q29 = 32'sd4;
            5'd28:   atan_q29 = 32'sd2;
            5'd29:   atan_q29 = 32'sd1;
            5'd30:   atan_q29 = 32'sd0;
            5'd31:   atan_q29 = 32'sd0;
            default: atan_q29 = 32'sd0;
        endcase
    endfunction

    // Bring a Q3.29 angle onto the internal fixed-point grid.
    function automatic logic signed [IW-1:0] align_atan(input logic signed [31:0] q);
        return IW'((64'(q) >>> ATAN_RSH) <<< ATAN_LSH);
    endfunction

    // Drop the guard LSBs, then clamp to the port range instead of wrapping.
    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] s;
        s = v >>> GUARD;
        if ((&s[IW-1:WIDTH-1]) || !(|s[IW-1:WIDTH-1])) begin
            saturate = s[WIDTH-1:0];
        end else if (s[IW-1]) begin
            saturate = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            saturate = {1'b0, {(WIDTH-1){1'b1}}};
        end
    endfunction

    state_t                 state_r;
    logic [CW-1:0]          iter_r;
    logic                   mode_r;
    logic signed [IW-1:0]   x_r;
    logic signed [IW-1:0]   y_r;
    logic signed [IW-1:0]   z_r;

    logic                   dir_pos_s;
    logic signed [IW-1:0]   x_sh_s;
    logic signed [IW-1:0]   y_sh_s;
    logic signed [IW-1:0]   atan_s;
    logic signed [IW-1:0]   x_nxt_s;
    logic signed [IW-1:0]   y_nxt_s;
    logic signed [IW-1:0]   z_nxt_s;

    // One micro-rotation step from the current x/y/z and iteration index.
    always_comb begin
        x_sh_s    = x_r >>> iter_r;
        y_sh_s    = y_r >>> iter_r;
        atan_s    = align_atan(atan_q29(5'(iter_r)));
        // Rotation steers by sign of z, vectoring by sign of y.
        dir_pos_s = mode_r ? y_r[IW-1] : ~z_r[IW-1];
        if (dir_pos_s) begin
            x_nxt_s = x_r - y_sh_s;
            y_nxt_s = y_r + x_sh_s;
            z_nxt_s = z_r - atan_s;
        end else begin
            x_nxt_s = x_r + y_sh_s;
            y_nxt_s = y_r - x_sh_s;
            z_nxt_s = z_r + atan_s;
        end
    end

    // Control FSM, datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            iter_r    <= {CW{1'b0}};
            mode_r    <= 1'b0;
            x_r       <= {IW{1'b0}};
            y_r       <= {IW{1'b0}};
            z_r       <= {IW{1'b0}};
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_x     <= {WIDTH{1'b0}};
            out_y     <= {WIDTH{1'b0}};
            out_z     <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        x_r      <= IW'(in_x) <<< GUARD;
                        y_r      <= IW'(in_y) <<< GUARD;
                        z_r      <= IW'(in_z) <<< GUARD;
                        mode_r   <= in_mode;
                        iter_r   <= {CW{1'b0}};
                        in_ready <= 1'b0;
                        state_r  <= ST_RUN;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    x_r <= x_nxt_s;
                    y_r <= y_nxt_s;
                    z_r <= z_nxt_s;
                    if (iter_r == CW'(ITERS - 1)) begin
                        // Capture the result straight from the final step.
                        out_x     <= saturate(x_nxt_s);
                        out_y     <= saturate(y_nxt_s);
                        out_z     <= saturate(z_nxt_s);
                        out_valid <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        iter_r    <= iter_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r   <= ST_DONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// tb_cordic_iter_engine
// Directed-vector bench for cordic_iter_engine (WIDTH=21, ITERS=16, GUARD=2).
// A real-arithmetic-derived reference model predicts every result bit-exactly;
// a negedge compare process checks handshake timing and results each cycle,
// and the stimulus adds hand-computed expectations within +/-32 LSB.
module tb_cordic_iter_engine;

    localparam int WIDTH = 21;
    localparam int ITERS = 16;
    localparam int GUARD = 2;
    localparam int FRAC  = WIDTH - 3;
    localparam int IW    = WIDTH + 2 * GUARD;
    localparam int TOL   = 32;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic                    in_mode = 1'b0;
    logic signed [WIDTH-1:0] in_x = '0;
    logic signed [WIDTH-1:0] in_y = '0;
    logic signed [WIDTH-1:0] in_z = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic signed [WIDTH-1:0] out_x;
    logic signed [WIDTH-1:0] out_y;
    logic signed [WIDTH-1:0] out_z;

    int checks = 0;
    int failures = 0;

    cordic_iter_engine #(.WIDTH(WIDTH), .ITERS(ITERS), .GUARD(GUARD)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input longint act, input longint exp);
        checks++;
        if (act < exp - TOL || act > exp + TOL) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d+/-%0d", name, act, exp, TOL);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint atan_ref_q29(input int i);
        real r;
        r = $atan(1.0 / (2.0 ** i)) * (2.0 ** 29);
        return longint'($floor(r + 0.5));
    endfunction

    function automatic longint atan_ref(input int i);
        int sh;
        sh = 29 - FRAC - GUARD;
        if (sh >= 0) return atan_ref_q29(i) >>> sh;
        else         return atan_ref_q29(i) <<< (-sh);
    endfunction

    function automatic longint wrap_iw(input longint v);
        return (v <<< (64 - IW)) >>> (64 - IW);
    endfunction

    function automatic longint sat_out(input longint v);
        longint hi, lo;
        hi = (longint'(1) <<< (WIDTH - 1)) - 1;
        lo = -(longint'(1) <<< (WIDTH - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic void cordic_model(input bit m, input longint x0, y0, z0,
                                         output longint ox, oy, oz);
        longint x, y, z, t;
        int d;
        x = wrap_iw(x0 * (longint'(1) <<< GUARD));
        y = wrap_iw(y0 * (longint'(1) <<< GUARD));
        z = wrap_iw(z0 * (longint'(1) <<< GUARD));
        for (int i = 0; i < ITERS; i++) begin
            if (m == 1'b0) d = (z >= 0) ? 1 : -1;
            else           d = (y < 0) ? 1 : -1;
            t = wrap_iw(x - d * (y >>> i));
            y = wrap_iw(y + d * (x >>> i));
            x = t;
            z = wrap_iw(z - d * atan_ref(i));
        end
        ox = sat_out(x >>> GUARD);
        oy = sat_out(y >>> GUARD);
        oz = sat_out(z >>> GUARD);
    endfunction

    // ---------------- per-cycle compare process ----------------
    // phase: 0 idle, 1 running, 2 result presented
    int     phase = 0;
    int     run_cycle = 0;
    longint exp_x, exp_y, exp_z;

    always @(negedge clk) begin
        if (reset) begin
            phase = 0;
            check("cmp_reset_in_ready", in_ready, 1);
            check("cmp_reset_out_valid", out_valid, 0);
        end else begin
            if (phase == 1) begin
                run_cycle++;
                if (run_cycle == ITERS + 1) phase = 2;
            end
            check("cmp_in_ready", in_ready, phase == 0);
            check("cmp_out_valid", out_valid, phase == 2);
            if (phase == 2) begin
                check("cmp_out_x", out_x, exp_x);
                check("cmp_out_y", out_y, exp_y);
                check("cmp_out_z", out_z, exp_z);
            end
            if (phase == 0 && in_valid) begin
                cordic_model(in_mode, in_x, in_y, in_z, exp_x, exp_y, exp_z);
                phase = 1;
                run_cycle = 0;
            end else if (phase == 2 && out_ready) begin
                phase = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_op(input logic m, input int x, input int y, input int z, input int hold,
                          output int ox, output int oy, output int oz, output int lat);
        @(posedge clk); #1;
        in_mode  = m;
        in_x     = WIDTH'(x);
        in_y     = WIDTH'(y);
        in_z     = WIDTH'(z);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) check("op_timeout", lat, ITERS + 1);
        ox = out_x;
        oy = out_y;
        oz = out_z;
        // Backpressure window: operands pulsed on in_valid must be ignored.
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            in_valid = k[0];
            in_mode  = ~m;
            in_x     = WIDTH'(k * 7919);
            in_y     = WIDTH'(-k * 3001);
            in_z     = WIDTH'(k * 101);
            @(negedge clk);
            check("bp_out_x_stable", out_x, ox);
            check("bp_out_y_stable", out_y, oy);
            check("bp_out_z_stable", out_z, oz);
            check("bp_in_ready_low", in_ready, 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_hs_in_ready", in_ready, 1);
        check("post_hs_out_valid", out_valid, 0);
    endtask

    initial begin
        int     t1x, t1y, t1z, rx, ry, rz, lat;
        longint mx, my, mz;

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out_x", out_x, 0);
        check("reset_out_y", out_y, 0);
        check("reset_out_z", out_z, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        @(posedge clk); #2 reset = 1'b0;

        // Pin the reference model to known constants.
        check("model_atan0_q29", atan_ref_q29(0), 421657428);
        cordic_model(1'b0, 159188, 0, 0, mx, my, mz);
        check_tol("model_t1_x", mx, 262144);
        check_tol("model_t1_y", my, 0);
        cordic_model(1'b1, 131072, 131072, 0, mx, my, mz);
        check_tol("model_t3_x", mx, 305253);
        check_tol("model_t3_z", mz, 205887);

        // 1: cos/sin of 0, latency
        run_op(1'b0, 159188, 0, 0, 0, t1x, t1y, t1z, lat);
        check("t1_latency", lat, 17);
        check_tol("t1_out_x", t1x, 262144);
        check_tol("t1_out_y", t1y, 0);

        // 2: pi/3
        run_op(1'b0, 159188, 0, 274520, 0, rx, ry, rz, lat);
        check_tol("t2_out_x", rx, 131072);
        check_tol("t2_out_y", ry, 227023);
        check_tol("t2_out_z", rz, 0);

        // 2b: -pi/3
        run_op(1'b0, 159188, 0, -274520, 0, rx, ry, rz, lat);
        check_tol("t2b_out_x", rx, 131072);
        check_tol("t2b_out_y", ry, -227023);

        // 3: vectoring, first quadrant
        run_op(1'b1, 131072, 131072, 0, 0, rx, ry, rz, lat);
        check_tol("t3_out_x", rx, 305253);
        check_tol("t3_out_y", ry, 0);
        check_tol("t3_out_z", rz, 205887);

        // 3b: vectoring, negative y
        run_op(1'b1, 131072, -131072, 0, 0, rx, ry, rz, lat);
        check_tol("t3b_out_x", rx, 305253);
        check_tol("t3b_out_z", rz, -205887);

        // 4: backpressure for 10 cycles with in_valid pulses
        run_op(1'b0, 159188, 0, 274520, 10, rx, ry, rz, lat);
        check_tol("t4_out_y", ry, 227023);
        repeat (5) @(negedge clk);
        check("t4_no_spurious_op", out_valid, 0);

        // 5: saturation
        run_op(1'b0, 1048575, 1048575, 0, 0, rx, ry, rz, lat);
        check("t5_out_x_sat", rx, 1048575);
        check("t5_out_y_sat", ry, 1048575);

        // 6: asynchronous reset at iteration 8 aborts the operation
        @(posedge clk); #1;
        in_mode  = 1'b0;
        in_x     = WIDTH'(159188);
        in_y     = '0;
        in_z     = '0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("t6_async_out_valid", out_valid, 0);
        check("t6_async_in_ready", in_ready, 1);
        @(negedge clk);
        @(posedge clk); #2 reset = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_no_result", out_valid, 0);
        run_op(1'b0, 159188, 0, 0, 0, rx, ry, rz, lat);
        check("t6_latency", lat, 17);
        check("t6_out_x", rx, t1x);
        check("t6_out_y", ry, t1y);
        check("t6_out_z", rz, t1z);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
